// File: rtl/sar_adc_tm.sv
// Successive-approximation ADC controller: vin (mV) -> largest N_BITS code with code*LSB_MV <= vin; ADC_ROUND_EN selects round-to-nearest.
// Latency: start accepted at edge 0, done pulses in the cycle after edge N_BITS; start-to-start period N_BITS+2.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy.
module sar_adc_tm #(
    parameter int N_BITS = 4,
    parameter int LSB_MV = 75,
    parameter int VIN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [VIN_W-1:0]  vin,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] code,
    output logic              overrange
);
    localparam int CW = VIN_W + N_BITS + $clog2(LSB_MV) + 1;
    localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] FULL_MV = CW'((2 ** N_BITS) * LSB_MV);
`ifdef ADC_ROUND_EN
    localparam logic [VIN_W:0] BIAS = (VIN_W + 1)'(LSB_MV / 2);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [VIN_W-1:0]  vin_q;
    logic [N_BITS-1:0] result_q;
    logic [KW-1:0]     k_q;
    logic              busy_q;
    logic              done_q;
    logic [N_BITS-1:0] code_q;
    logic              ovr_q;

    logic [N_BITS-1:0] cand;
    logic [N_BITS-1:0] result_d;
    logic [VIN_W:0]    vin_cmp;
    logic [CW-1:0]     cand_mv;
    logic [CW-1:0]     vin_ext;

    // Trial DAC: bits below k are still zero, so cand is the trial with bit k set.
    always_comb begin
        cand    = result_q | (N_BITS'(1) << k_q);
        cand_mv = CW'(cand) * CW'(LSB_MV);
`ifdef ADC_ROUND_EN
        vin_cmp = {1'b0, vin_q} + BIAS;
`else
        vin_cmp = {1'b0, vin_q};
`endif
        vin_ext  = CW'(vin_cmp);
        result_d = (cand_mv <= vin_ext) ? cand : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vin_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            code_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        vin_q    <= vin;
                        result_q <= '0;
                        k_q      <= KW'(N_BITS - 1);
                        busy_q   <= 1'b1;
                        state_q  <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    result_q <= result_d;
                    if (k_q != '0) begin
                        k_q <= k_q - KW'(1);
                    end else begin
                        code_q  <= result_d;
                        ovr_q   <= (vin_ext >= FULL_MV);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign code      = code_q;
    assign overrange = ovr_q;

endmodule

// File: doc/sar_adc_tm.md
Name: sar_adc_tm

Overview:
- Successive-approximation ADC controller; the inverse of the 4-bit tape-machine DAC (DAC output = code × 75 mV).
- Takes a sampled input voltage as an unsigned integer in millivolts and returns the N-bit code whose DAC value is the largest not exceeding the input.
- Resolves one bit per clock, MSB first, against an internal trial DAC (candidate × LSB_MV).
- Sits in front of the DAC so a bench can close the loop: vin → code → DAC.

Parameters:
- N_BITS, 4, code width; matches the DAC input width.
- LSB_MV, 75, millivolts per code step; matches the DAC scale factor of 0.075 V.
- VIN_W, 12, width of the vin input in integer millivolts.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- vin  input  VIN_W  input voltage, unsigned mV; latched on start acceptance.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; code and overrange valid.
- code  output  N_BITS  last conversion result; holds between conversions.
- overrange  output  1  last conversion saturated (vin ≥ 2^N_BITS × LSB_MV).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, code=0, overrange=0; internal vin_q, result and bit index cleared. Takes effect immediately, with no clock required.
- Reset mid-conversion: conversion aborted; no done pulse; code keeps its reset value of 0.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - busy=0.
  - Edge with start=1: vin_q<=vin; result<=0; k<=N_BITS-1; busy<=1; go to CONVERT.
  - start=0: stay in IDLE.
- CONVERT, one bit per edge:
  - cand = result | (1<<k).
  - If cand×LSB_MV ≤ vin_q, result bit k<=1; else bit k<=0.
  - If k>0: k<=k-1 and stay in CONVERT.
  - If k==0: code<=final result, overrange<=(vin_q ≥ (1<<N_BITS)×LSB_MV), done<=1, go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy stays 1.
  - Next edge: done<=0, busy<=0, go to IDLE.
- Latency: start accepted at edge 0; done high in the cycle after edge N_BITS; code valid from that same cycle. Minimum start-to-start period is N_BITS+2 cycles.
- start in CONVERT or DONE is ignored (not queued). vin changes after acceptance have no effect.
- Arithmetic: cand×LSB_MV is computed at width VIN_W+N_BITS+clog2(LSB_MV)+1, with no truncation; all comparisons unsigned.
- Saturation: any vin ≥ (2^N_BITS-1)×LSB_MV yields code = all ones. overrange flags only vin ≥ 2^N_BITS×LSB_MV.
- Invariant (default build): code×LSB_MV ≤ vin_q < (code+1)×LSB_MV whenever overrange=0.
- No X/Z is ever driven on any output.

Optional Feature:
- Macro: ADC_ROUND_EN.
- Defined (round to nearest):
  - Every comparison uses vin_q + (LSB_MV>>1) in place of vin_q, with the sum widened by 1 bit.
  - overrange uses the same biased value.
  - For LSB_MV=75 the bias is 37: vin=37 → 0, vin=38 → 1, vin=1163 → 15 with overrange=1.
- Undefined: truncating behaviour as specified above.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset low mid-CONVERT (vin=600, start pulse, rst_n=0 after 2 edges) → busy=0, done never pulses, code=0, overrange=0 immediately; next start converts normally.
- Sweep vin=0, 74, 75, 149, 150, 600, 1124, 1125, 1199 (default build) → code=0, 0, 1, 1, 2, 8, 14, 15, 15; overrange=0 for all; done high exactly 5 cycles after the start edge.
- vin=1200 and vin=4095 → code=15, overrange=1. Then vin=0 → code=0, overrange cleared.
- Handshake: start held high continuously with vin=300 → conversions every 6 cycles, code=4. A start pulse during CONVERT or DONE is ignored. vin changed to 900 mid-conversion → result still 4.
- Loop-back with DAC: for codes 0..15, drive vin=code×75+k for k in {0, 74} → ADC output equals code; DAC(ADC) output ≤ vin.
- ADC_ROUND_EN build: vin=37 → 0; 38 → 1; 112 → 1; 113 → 2; 1162 → 15 with overrange=0; 1163 → 15 with overrange=1.
